rx_buffer_ctrl: RTL and testbench

//  Receive-buffer controller between the UART receiver control unit and the host-side consumer.
//  - Captures each byte strobed by load_buffer, with its framing-error tag, into a DEPTH-entry FIFO.
//  - Presents bytes one at a time through a registered output stage and a ready/ack handshake.
//  - Flags overrun when the receiver delivers a byte while storage is full.

---
 rtl/rx_pkg.sv | 19 +
 rtl/rx_fifo_mem.sv | 69 ++++++
 rtl/rx_buffer_ctrl.sv | 111 +++++++++++
 tb/tb_rx_buffer_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_pkg                                                                     |
// | Shared types and constants for the receive-buffer controller.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } drain_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DROP_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/rx_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_fifo_mem                                                                |
// | Storage array with wrapping pointers and occupancy count; the caller gates |
// | wr_en_i/pop_i so they are only asserted when legal.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rx_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i)
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_i)
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({wr_en_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage itself needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr_en_i)
      mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/rx_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_buffer_ctrl                                                             |
// | UART receive buffer: FIFO capture, overrun flag, drain FSM feeding a       |
// | registered ready/ack output. Define RX_DROP_CNT_EN for the drop counter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rx_buffer_ctrl
  import rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         load_buffer,
  input  logic [DATA_W-1:0]            packet_data,
  input  logic                         framing_error,
  input  logic                         data_read,
  input  logic                         clear_errors,
  output logic [DATA_W-1:0]            rx_data,
  output logic                         rx_frame_err,
  output logic                         data_ready,
  output logic                         overrun_error,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef RX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]        drop_count
`endif
);

  drain_state_t      state_q, state_d;
  logic [DATA_W:0]   head;
  logic              full, empty;
  logic              pop, wr_en, drop;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_frame_err_q;
  logic              overrun_q;

  // A pop in FETCH frees a slot in the same cycle, so a write is legal even when full.
  assign pop   = (state_q == FETCH);
  assign wr_en = load_buffer && (!full || pop);
  assign drop  = load_buffer && full && !pop;

  rx_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .wr_en_i   (wr_en),
    .wr_data_i ({framing_error, packet_data}),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = FETCH;
      FETCH:   state_d = SHOW;
      SHOW:    if (data_read) state_d = (!empty || wr_en) ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      rx_data_q      <= '0;
      rx_frame_err_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH)
        {rx_frame_err_q, rx_data_q} <= head;
      if (drop)
        overrun_q <= 1'b1;
      else if (clear_errors)
        overrun_q <= 1'b0;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign data_ready    = (state_q == SHOW);
  assign overrun_error = overrun_q;

`ifdef RX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // A drop coinciding with a clear restarts the count at one rather than zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      drop_cnt_q <= '0;
    else if (drop && clear_errors)
      drop_cnt_q <= DROP_CNT_W'(1);
    else if (drop && (drop_cnt_q != '1))
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    else if (clear_errors)
      drop_cnt_q <= '0;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rx_buffer_ctrl                                                          |
// | Directed self-checking bench for rx_buffer_ctrl (DATA_W=8, DEPTH=4).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rx_buffer_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       load_buffer = 1'b0;
  logic [7:0] packet_data = '0;
  logic       framing_error = 1'b0;
  logic       data_read = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       data_ready;
  logic       overrun_error;
  logic [2:0] fifo_count;
`ifdef RX_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  rx_buffer_ctrl #(.DATA_W(8), .DEPTH(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .load_buffer   (load_buffer),
    .packet_data   (packet_data),
    .framing_error (framing_error),
    .data_read     (data_read),
    .clear_errors  (clear_errors),
    .rx_data       (rx_data),
    .rx_frame_err  (rx_frame_err),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .fifo_count    (fifo_count)
`ifdef RX_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic fe);
    load_buffer   = 1'b1;
    packet_data   = d;
    framing_error = fe;
    tick();
    load_buffer   = 1'b0;
    framing_error = 1'b0;
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!data_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, data_ready}, 32'd1);
  endtask

  logic [7:0] drain_exp [4] = '{8'h03, 8'h04, 8'h05, 8'h07};

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_ready", {31'd0, data_ready}, 32'd0);
    check_eq("rst_data", {24'd0, rx_data}, 32'h0);
    check_eq("rst_ovr", {31'd0, overrun_error}, 32'd0);
    check_eq("rst_cnt", {29'd0, fifo_count}, 32'd0);
    n_rst = 1'b1;
    tick();

    // 1: single byte latency, ignored read while idle
    read_pulse();
    check_eq("idle_read_ignored", {29'd0, fifo_count}, 32'd0);
    load_byte(8'hA5, 1'b0);
    check_eq("lat_e0", {31'd0, data_ready}, 32'd0);
    tick();
    check_eq("lat_e1", {31'd0, data_ready}, 32'd0);
    tick();
    check_eq("lat_e2", {31'd0, data_ready}, 32'd1);
    check_eq("t1_data", {24'd0, rx_data}, 32'hA5);
    check_eq("t1_cnt", {29'd0, fifo_count}, 32'd0);
    read_pulse();
    check_eq("t1_ready_low", {31'd0, data_ready}, 32'd0);
    check_eq("t1_keep_data", {24'd0, rx_data}, 32'hA5);

    // 2: framing tag follows its byte
    load_byte(8'h3C, 1'b1);
    wait_ready("t2_ready_a");
    check_eq("t2_data_a", {24'd0, rx_data}, 32'h3C);
    check_eq("t2_fe_a", {31'd0, rx_frame_err}, 32'd1);
    read_pulse();
    load_byte(8'h5A, 1'b0);
    wait_ready("t2_ready_b");
    check_eq("t2_data_b", {24'd0, rx_data}, 32'h5A);
    check_eq("t2_fe_b", {31'd0, rx_frame_err}, 32'd0);
    read_pulse();

    // 3: fill and overrun
    for (int i = 1; i <= 6; i++) load_byte(8'(i), 1'b0);
    check_eq("t3_ready", {31'd0, data_ready}, 32'd1);
    check_eq("t3_data", {24'd0, rx_data}, 32'h01);
    check_eq("t3_cnt", {29'd0, fifo_count}, 32'd4);
    check_eq("t3_ovr", {31'd0, overrun_error}, 32'd1);
`ifdef RX_DROP_CNT_EN
    check_eq("t3_drop1", {24'd0, drop_count}, 32'd1);
`endif
    load_byte(8'h08, 1'b0);
`ifdef RX_DROP_CNT_EN
    check_eq("t3_drop2", {24'd0, drop_count}, 32'd2);
`endif
    clear_errors = 1'b1;
    load_byte(8'h09, 1'b0);
    clear_errors = 1'b0;
    check_eq("t3_ovr_wins", {31'd0, overrun_error}, 32'd1);
`ifdef RX_DROP_CNT_EN
    check_eq("t3_drop_clr_hit", {24'd0, drop_count}, 32'd1);
`endif
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check_eq("t3_ovr_clr", {31'd0, overrun_error}, 32'd0);
`ifdef RX_DROP_CNT_EN
    check_eq("t3_drop_clr", {24'd0, drop_count}, 32'd0);
`endif
    check_eq("t3_cnt_hold", {29'd0, fifo_count}, 32'd4);

    // 4: write + pop while full
    read_pulse();
    check_eq("t4_fetch_ready", {31'd0, data_ready}, 32'd0);
    load_byte(8'h07, 1'b0);
    check_eq("t4_cnt", {29'd0, fifo_count}, 32'd4);
    check_eq("t4_ovr", {31'd0, overrun_error}, 32'd0);
    check_eq("t4_data", {24'd0, rx_data}, 32'h02);
    for (int i = 0; i < 4; i++) begin
      read_pulse();
      wait_ready("t4_drain_ready");
      check_eq("t4_drain", {24'd0, rx_data}, {24'd0, drain_exp[i]});
    end
    read_pulse();
    check_eq("t4_end_ready", {31'd0, data_ready}, 32'd0);
    check_eq("t4_end_cnt", {29'd0, fifo_count}, 32'd0);

    // 5: streaming with immediate reads, pointers wrap
    for (int i = 0; i < 10; i++) begin
      load_byte(8'h20 + 8'(i), 1'b0);
      wait_ready("t5_ready");
      check_eq("t5_data", {24'd0, rx_data}, 32'h20 + i);
      read_pulse();
    end
    check_eq("t5_cnt", {29'd0, fifo_count}, 32'd0);

    // 6: async reset mid-SHOW with three bytes stored
    for (int i = 0; i < 4; i++) load_byte(8'hA0 + 8'(i), 1'b0);
    check_eq("t6_pre_ready", {31'd0, data_ready}, 32'd1);
    check_eq("t6_pre_cnt", {29'd0, fifo_count}, 32'd3);
    #2 n_rst = 1'b0;
    #1;
    check_eq("t6_rst_ready", {31'd0, data_ready}, 32'd0);
    check_eq("t6_rst_data", {24'd0, rx_data}, 32'h0);
    check_eq("t6_rst_cnt", {29'd0, fifo_count}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();
    load_byte(8'hC7, 1'b0);
    wait_ready("t6_ready");
    check_eq("t6_data", {24'd0, rx_data}, 32'hC7);
    read_pulse();
    tick();
    check_eq("t6_no_stale", {31'd0, data_ready}, 32'd0);
    check_eq("t6_cnt", {29'd0, fifo_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
